ctc8: RTL and testbench
=======================

CTC8 -- requirements
Module: ctc8

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; the ports are named clk and reset.
REQ-002 Parameter PRESCALE, default 1, SHALL set the clock cycles per count step; legal range is 1..255.
REQ-003 Parameter DOWN, default 0, SHALL select the count direction: 0 = up, 1 = down.
REQ-004 Port clk, input, 1 bit: rising-edge system clock.
REQ-005 Port reset, input, 1 bit: asynchronous active-low reset (0 = in reset).
REQ-006 Port count, output, 3 bits: current counter value, registered.

Function
REQ-007 The block SHALL hold an internal 3-bit binary state bin and an 8-bit prescale counter pre.
REQ-008 On each rising clk with reset=1, pre SHALL increment.
- When pre equals PRESCALE-1, pre SHALL clear to 0 and bin SHALL take one step.
REQ-009 Up mode (DOWN=0): a step SHALL be bin+1 modulo 8, so 7 wraps to 0.
REQ-010 Down mode (DOWN=1): a step SHALL be bin-1 modulo 8, so 0 wraps to 7.
REQ-011 With PRESCALE=1, bin SHALL step on every rising clk edge; period = 8 clocks.
REQ-012 With PRESCALE=N, bin SHALL step once every N clocks; full period = 8*N clocks.
REQ-013 count SHALL be driven directly from registers, with no combinational path from reset or clk; Gray mode per REQ-018.
REQ-014 The first step after reset release SHALL occur on the PRESCALE-th rising edge with reset=1, counting from the first such edge.
REQ-015 There SHALL be no stall, load or enable condition; the counter runs freely while reset=1.
REQ-016 PRESCALE values outside 1..255 SHALL be rejected at elaboration by an error.

Reset
REQ-017 While reset=0, bin and pre SHALL be 0 and count SHALL be 0, asynchronously and immediately, regardless of clk.
- Asserting reset mid-count SHALL abort the current prescale interval.
- After release, counting SHALL restart per REQ-014.

Configuration
REQ-018 Macro CTC8_GRAY_OUT_EN selects the output coding.
- Defined: count SHALL be a register holding the Gray code of bin (bin XOR (bin>>1)), updated in the same cycle as bin.
- Up sequence is 000,001,011,010,110,111,101,100, with exactly one bit changing per step including the wrap.
- Not defined: count SHALL equal bin, plain binary.

Verification
REQ-019 Defaults, reset=0 for 10 ns then 1, clk period 10 ns -> count reads 0,1,2,...,7,0,1 on successive rising edges; the 7->0 wrap is checked.
REQ-020 Reset asserted asynchronously while count=5, between clock edges -> count=0 within the same time step; after release it resumes 1,2,...
REQ-021 DOWN=1, PRESCALE=1, reset released -> count reads 7,6,5,...,0,7.
REQ-022 PRESCALE=3, up mode -> count holds each value for exactly 3 clocks; the first change 0->1 occurs on the 3rd rising edge after release.
REQ-023 CTC8_GRAY_OUT_EN defined, defaults -> count reads 1,3,2,6,7,5,4,0; Hamming distance is 1 between consecutive values.
REQ-024 Reset held low for 20 clocks -> count stays 0 throughout, with no glitches.

Source files
------------

// File: rtl/ctc8.sv
// rtl/ctc8.sv - free-running 3-bit up/down counter with clock prescaler
// CTC8_GRAY_OUT_EN: when defined, count is the registered Gray code of the binary state
module ctc8 #(
  parameter int PRESCALE = 1,
  parameter int DOWN     = 0
) (
  input  logic       clk,
  input  logic       reset,
  output logic [2:0] count
);

  localparam logic [7:0] PRE_LAST = 8'(PRESCALE - 1);

  generate
    if (PRESCALE < 1 || PRESCALE > 255) begin : g_bad_prescale
      $error("ctc8: PRESCALE must be within 1..255");
    end
  endgenerate

  logic [7:0] pre_q, pre_d;
  logic [2:0] bin_q, bin_d;
  logic [2:0] count_q, count_d;

  always_comb begin
    pre_d = pre_q + 8'd1;
    bin_d = bin_q;
    if (pre_q == PRE_LAST) begin
      pre_d = 8'd0;
      bin_d = (DOWN != 0) ? bin_q - 3'd1 : bin_q + 3'd1;
    end
    // count tracks the next bin so both registers change on the same edge
`ifdef CTC8_GRAY_OUT_EN
    count_d = bin_d ^ (bin_d >> 1);
`else
    count_d = bin_d;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q   <= 8'd0;
      bin_q   <= 3'd0;
      count_q <= 3'd0;
    end else begin
      pre_q   <= pre_d;
      bin_q   <= bin_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_ctc8.sv
// tb/tb_ctc8.sv - self-checking bench for ctc8: up, down and prescaled instances
module tb_ctc8;

  logic       clk;
  logic       reset;
  logic [2:0] cnt_up, cnt_dn, cnt_p3;

  int checks;
  int failures;

  ctc8 #(.PRESCALE(1), .DOWN(0)) u_up (.clk(clk), .reset(reset), .count(cnt_up));
  ctc8 #(.PRESCALE(1), .DOWN(1)) u_dn (.clk(clk), .reset(reset), .count(cnt_dn));
  ctc8 #(.PRESCALE(3), .DOWN(0)) u_p3 (.clk(clk), .reset(reset), .count(cnt_p3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] up;
    logic [2:0] dn;
    logic [2:0] p3;
  } vec_t;

  vec_t table_v[12];
  vec_t sb_q[$];

  logic [2:0] m_up, m_dn, m_p3;
  int         m_p3_pre;

  function automatic logic [2:0] enc(input logic [2:0] b);
`ifdef CTC8_GRAY_OUT_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_up = 3'd0;
    m_dn = 3'd0;
    m_p3 = 3'd0;
    m_p3_pre = 0;
  endtask

  // one clock: advance the model, queue its prediction, then compare what the DUTs produced
  task automatic sb_cycle();
    vec_t e, got;
    @(posedge clk);
    m_up = m_up + 3'd1;
    m_dn = m_dn - 3'd1;
    if (m_p3_pre == 2) begin
      m_p3_pre = 0;
      m_p3 = m_p3 + 3'd1;
    end else begin
      m_p3_pre++;
    end
    e.up = enc(m_up);
    e.dn = enc(m_dn);
    e.p3 = enc(m_p3);
    sb_q.push_back(e);
    #1;
    got = sb_q.pop_front();
    chk("sb_up", cnt_up, got.up);
    chk("sb_dn", cnt_dn, got.dn);
    chk("sb_p3", cnt_p3, got.p3);
  endtask

  initial begin
    logic [2:0] prev_up;
    bit found;
    checks = 0;
    failures = 0;

    table_v[0]  = '{3'd1, 3'd7, 3'd0};
    table_v[1]  = '{3'd2, 3'd6, 3'd0};
    table_v[2]  = '{3'd3, 3'd5, 3'd1};
    table_v[3]  = '{3'd4, 3'd4, 3'd1};
    table_v[4]  = '{3'd5, 3'd3, 3'd1};
    table_v[5]  = '{3'd6, 3'd2, 3'd2};
    table_v[6]  = '{3'd7, 3'd1, 3'd2};
    table_v[7]  = '{3'd0, 3'd0, 3'd2};
    table_v[8]  = '{3'd1, 3'd7, 3'd3};
    table_v[9]  = '{3'd2, 3'd6, 3'd3};
    table_v[10] = '{3'd3, 3'd5, 3'd3};
    table_v[11] = '{3'd4, 3'd4, 3'd4};

    reset = 1'b0;
    #2;
    chk("rst_up", cnt_up, 3'd0);
    chk("rst_dn", cnt_dn, 3'd0);
    chk("rst_p3", cnt_p3, 3'd0);
    #8;
    reset = 1'b1;

    prev_up = 3'd0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      chk("tbl_up", cnt_up, enc(table_v[i].up));
      chk("tbl_dn", cnt_dn, enc(table_v[i].dn));
      chk("tbl_p3", cnt_p3, enc(table_v[i].p3));
`ifdef CTC8_GRAY_OUT_EN
      checks++;
      if ($countones(cnt_up ^ prev_up) != 1) begin
        failures++;
        $display("FAIL gray_hamming: got %0d->%0d expected one bit change", prev_up, cnt_up);
      end
`endif
      prev_up = cnt_up;
    end

    m_up = 3'd4;
    m_dn = 3'd4;
    m_p3 = 3'd4;
    m_p3_pre = 0;
    for (int i = 0; i < 30; i++) sb_cycle();

    found = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      @(negedge clk);
      if (cnt_up === enc(3'd5)) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL wait_count5: got timeout expected count 5 within 16 cycles");
    end

    #2;
    reset = 1'b0;
    #1;
    chk("async_up", cnt_up, 3'd0);
    chk("async_dn", cnt_dn, 3'd0);
    chk("async_p3", cnt_p3, 3'd0);
    model_reset();

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold_up", cnt_up, 3'd0);
      chk("hold_dn", cnt_dn, 3'd0);
      chk("hold_p3", cnt_p3, 3'd0);
    end

    reset = 1'b1;
    for (int i = 0; i < 20; i++) sb_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
